// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared opcode and FSM state types for the ALU execution stage.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        RELEASE
    } alu_state_t;

    localparam int unsigned DEFAULT_MUL_LATENCY = 3;

endpackage

// File: rtl/alu_mul_pipe.sv
// alu_mul_pipe: MUL_LATENCY-stage unsigned 8x8 multiplier with a valid shift chain.
// Stage 0 registers the operands, stage 1 forms the product, later stages delay it.
module alu_mul_pipe #(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] product
);

    logic [MUL_LATENCY-1:0] vld_q, vld_d;
    logic [7:0]             a_q, a_d, b_q, b_d;
    logic [15:0]            prod_q [1:MUL_LATENCY-1];
    logic [15:0]            prod_d [1:MUL_LATENCY-1];

    // Next-stage values: shift valid, capture operands on in_valid, advance product.
    always_comb begin
        vld_d = {vld_q[MUL_LATENCY-2:0], in_valid};
        a_d   = a_q;
        b_d   = b_q;
        if (in_valid) begin
            a_d = a;
            b_d = b;
        end
        prod_d    = prod_q;
        prod_d[1] = 16'(a_q) * 16'(b_q);
        for (int unsigned i = 2; i < MUL_LATENCY; i++) begin
            prod_d[i] = prod_q[i-1];
        end
    end

    // Valid chain is reset so an in-flight multiply is discarded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Datapath registers; qualified by the valid chain, so no reset needed.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        prod_q <= prod_d;
    end

    assign out_valid = vld_q[MUL_LATENCY-1];
    assign product   = prod_q[MUL_LATENCY-1];

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: operation-execution stage with start/done handshake.
// Optional feature macro: ALU_MUL_EN (pipelined multiply; otherwise mul_op acts as no_op).
module alu_exec_unit
    import tinyalu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        busy
);

    if (MUL_LATENCY < 2 || MUL_LATENCY > 4) begin : g_bad_latency
        $error("alu_exec_unit: MUL_LATENCY must be 2..4");
    end

    alu_state_t state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    operation_t op_q, op_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;

`ifdef ALU_MUL_EN
    logic [1:0]  cnt_q, cnt_d;
    logic        mul_start;
    logic        mul_valid;
    logic [15:0] mul_prod;

    assign mul_start = (state_q == IDLE) && start && (operation_t'(op) == mul_op);

    alu_mul_pipe #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mul_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (mul_start),
        .a         (A),
        .b         (B),
        .out_valid (mul_valid),
        .product   (mul_prod)
    );
`endif

    // Next-state, operand capture, result mux and done pulse generation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef ALU_MUL_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = operation_t'(op);
                    state_d = EXEC;
`ifdef ALU_MUL_EN
                    if (operation_t'(op) == mul_op) begin
                        state_d = MUL;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            EXEC: begin
                done_d  = 1'b1;
                state_d = RELEASE;
                case (op_q)
                    add_op:  result_d = {7'b0, {1'b0, a_q} + {1'b0, b_q}};
                    and_op:  result_d = {8'b0, a_q & b_q};
                    xor_op:  result_d = {8'b0, a_q ^ b_q};
                    rst_op:  result_d = '0;
                    default: result_d = result_q;
                endcase
            end
`ifdef ALU_MUL_EN
            MUL: begin
                cnt_d = cnt_q + 2'd1;
                if (mul_valid && (cnt_q == 2'(MUL_LATENCY - 1))) begin
                    result_d = mul_prod;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = RELEASE;
                end
            end
`endif
            RELEASE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= no_op;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
// Follows the ALU_MUL_EN macro so it matches the build of the DUT.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(
        .MUL_LATENCY(3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, expect done exactly lat edges later.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] o, input logic [15:0] exp, input int lat);
        A = a; B = b; op = o; start = 1'b1;
        tick();
        chk({tag, "_busy_t0"}, 16'(busy), 16'd1);
        chk({tag, "_done_t0"}, 16'(done), 16'd0);
        A = ~a; B = ~b; op = 3'b001;
        for (int i = 1; i < lat; i++) begin
            tick();
            chk({tag, "_done_early"}, 16'(done), 16'd0);
        end
        tick();
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_result"}, result, exp);
        start = 1'b0;
        tick();
        chk({tag, "_done_low"}, 16'(done), 16'd0);
        chk({tag, "_busy_low"}, 16'(busy), 16'd0);
        chk({tag, "_result_hold"}, result, exp);
    endtask

    logic [15:0] hold_val;

    initial begin
        // Reset held with start high: nothing may be accepted.
        reset_n = 1'b0; start = 1'b1; op = 3'b001; A = 8'h11; B = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_done", 16'(done), 16'd0);
            chk("rst_result", result, 16'h0000);
            chk("rst_busy", 16'(busy), 16'd0);
        end
        // Release reset with start still high: accepted on the release edge.
        reset_n = 1'b1;
        do_op("add_carry", 8'hFF, 8'h01, 3'b001, 16'h0100, 1);
        do_op("and", 8'hF0, 8'h3C, 3'b010, 16'h0030, 1);
        do_op("xor", 8'hF0, 8'h3C, 3'b011, 16'h00CC, 1);

`ifdef ALU_MUL_EN
        do_op("mul", 8'hFF, 8'hFF, 3'b100, 16'hFE01, 3);
        hold_val = 16'hFE01;
`else
        do_op("mul_disabled", 8'h03, 8'h04, 3'b100, 16'h00CC, 1);
        hold_val = 16'h00CC;
`endif
        do_op("reserved101", 8'h12, 8'h34, 3'b101, hold_val, 1);
        do_op("rst_op", 8'h12, 8'h34, 3'b111, 16'h0000, 1);

        // Held start after completion must not retrigger.
        A = 8'h12; B = 8'h34; op = 3'b001; start = 1'b1;
        tick();
        tick();
        chk("held_done", 16'(done), 16'd1);
        chk("held_result", result, 16'h0046);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("held_no_retrigger", 16'(done), 16'd0);
            chk("held_busy", 16'(busy), 16'd1);
        end
        start = 1'b0;
        tick();
        chk("rearm_idle", 16'(busy), 16'd0);
        A = 8'h80; B = 8'h80; start = 1'b1;
        tick();
        chk("rearm_accept", 16'(busy), 16'd1);
        tick();
        chk("rearm_done", 16'(done), 16'd1);
        chk("rearm_result", result, 16'h0100);
        start = 1'b0;
        tick();

`ifdef ALU_MUL_EN
        // Reset during the second cycle of a multiply discards it.
        A = 8'h07; B = 8'h09; op = 3'b100; start = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
`else
        // Reset while an op is in flight discards it.
        A = 8'h01; B = 8'h01; op = 3'b001; start = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
`endif
        chk("midrst_done", 16'(done), 16'd0);
        chk("midrst_result", result, 16'h0000);
        chk("midrst_busy", 16'(busy), 16'd0);
        reset_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_late_done", 16'(done), 16'd0);
            chk("midrst_idle", 16'(busy), 16'd0);
        end
        do_op("add_after_rst", 8'h02, 8'h03, 3'b001, 16'h0005, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Operation-execution stage of the ALU testbench DUT; sits directly downstream of the ALU bus-functional driver.
- Accepts one operation per start/done handshake on 8-bit operands A/B with a 3-bit opcode.
- Logical/add ops complete in one cycle; multiply runs through a 3-cycle pipeline.
- Produces a registered 16-bit result and a one-cycle done pulse that the driver and monitors sample.

## Interface
Parameters:
- MUL_LATENCY, 3, cycles from capture edge to done for mul_op; legal values 2..4.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, synchronous, active-low.
- A  input  8  operand A, unsigned bit pattern.
- B  input  8  operand B, unsigned bit pattern.
- op  input  3  opcode (operation_t).
- start  input  1  request; held high by requester until done is seen.
- done  output  1  one-cycle completion pulse.
- result  output  16  registered result; holds value until next completing op.
- busy  output  1  high from capture edge until the FSM returns to IDLE.

## Operation
- Opcodes:
  - no_op=000
  - add_op=001
  - and_op=010
  - xor_op=011
  - mul_op=100
  - rst_op=111
  - 101/110 reserved, handled as no_op.
- Arithmetic:
  - add: {7'b0, A+B} (9-bit sum, carry kept).
  - and/xor: {8'b0, A op B}.
  - mul: unsigned 8x8 → 16 bits.
- no_op/reserved: done pulses; result unchanged.
- rst_op: done pulses; result ← 0.
- A, B, op captured on the accept edge; later input changes are ignored until the next accept.
- FSM states:
  - IDLE: start=1 accepts the op (captures operands and opcode) → EXEC (single-cycle ops) or MUL (mul_op).
  - EXEC: result/done written → RELEASE.
  - MUL: cycle counter runs; at count MUL_LATENCY-1, result/done written → RELEASE.
  - RELEASE: waits for start=0 → IDLE. Prevents one held start from triggering twice.
- start is ignored in EXEC/MUL/RELEASE; no queueing.
- reset_n=0 at any edge:
  - state → IDLE, counter → 0; in-flight multiply discarded.
  - reset dominates start.
- Reset values: done=0, result=16'h0000, busy=0.

## Timing
- Edge t0: start sampled high in IDLE → capture; busy=1 after t0.
- Single-cycle op: result and done visible after t1; done low after t2.
- mul_op: result and done visible after t(MUL_LATENCY), i.e. t3 by default.
- done is high for exactly one cycle per accepted op, never two consecutive cycles.
- RELEASE: start low at edge tn → IDLE after tn; busy drops after tn.
  - Earliest next accept is at tn+1.
  - Minimum single-op turnaround is 3 cycles with an ideal requester.
- Reset released at edge tr (reset_n sampled high): start may be accepted at tr.

## Configuration
- ALU_MUL_EN defined:
  - mul_op executes via the pipelined multiplier.
  - MUL state and counter present.
- ALU_MUL_EN undefined:
  - multiplier, MUL state and counter are compiled out.
  - mul_op is handled as reserved: done at t1, result unchanged.

## Structure
- tinyalu_pkg holds:
  - operation_t enum with the encodings above.
  - alu_state_t {IDLE, EXEC, MUL, RELEASE}.
  - localparam DEFAULT_MUL_LATENCY=3.
- Sub-module alu_mul_pipe:
  - MUL_LATENCY-stage unsigned 8x8 multiplier with valid shift chain.
  - Instantiated only under ALU_MUL_EN.
  - Its output-valid feeds the MUL→RELEASE transition.
- Result mux, done register and FSM live in alu_exec_unit.

## Test plan
- Reset: hold reset_n=0 with start=1, op=add for 3 edges → done=0, result=0, busy=0 throughout; no op accepted.
- add A=8'hFF, B=8'h01 → result=16'h0100, done single pulse 1 cycle after accept; and A=8'hF0, B=8'h3C → 16'h0030; xor same operands → 16'h00CC.
- mul A=8'hFF, B=8'hFF → result=16'hFE01, done exactly 3 cycles after accept; operands changed mid-op are ignored.
- Held start: keep start=1 for 6 cycles after add completes → exactly one done pulse; start low for one cycle re-arms; next add is accepted.
- rst_op after result=16'hFE01 → result=16'h0000 with done pulse; op=3'b101 → done pulse, result unchanged.
- reset_n=0 for one edge during cycle 2 of a multiply → no done, result=0, state IDLE; a following add 2+3 gives result=16'h0005.
- ALU_MUL_EN undefined: mul A=3, B=4 → done at t1, result unchanged.
